// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types, frame constants and baud helper for the UART TX path.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : 8N1 frame serialiser; define UART_TX_PARITY_EN for an even parity bit.
// Revision : 1.0
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       idle
);

    localparam int               c_CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       c_IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_tx     <= STOP_BIT;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift  <= data;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_tx     <= START_BIT;
                        r_state  <= START;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^data;
`endif
                    end
                end
                START: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_idx == c_IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= STOP_BIT;
                            r_state <= STOP;
`endif
                        end else begin
                            // The next bit is presented as the shift advances
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_tx    <= STOP_BIT;
                        r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= STOP_BIT;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign idle = (r_state == IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Round-robin sharing of one UART TX pin among NUM_REQ byte sources.
//            Parity option selected by macro UART_TX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int c_ID_W         = $clog2(NUM_REQ);
    localparam int c_CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    logic [c_ID_W-1:0] r_rr_ptr;
    logic [c_ID_W-1:0] r_grant_id;
    logic [c_ID_W-1:0] w_winner;
    logic              w_found;
    logic              w_idle;
    logic              w_load;
    logic [7:0]        w_data;

    // Search starts just after the last winner so every source gets a turn
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = c_ID_W'(idx);
            end
        end
    end

    assign w_load = w_idle & w_found;
    assign w_data = req_data[{w_winner, 3'b000} +: 8];

    always_comb begin
        req_ready = '0;
        if (w_load) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= c_ID_W'(NUM_REQ - 1);
            r_grant_id <= '0;
        end else if (w_load) begin
            r_rr_ptr   <= w_winner;
            r_grant_id <= w_winner;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(c_CLKS_PER_BIT)
    ) u_serializer (
        .clk (clk),
        .rst (rst),
        .load(w_load),
        .data(w_data),
        .tx  (tx),
        .idle(w_idle)
    );

    assign busy     = ~w_idle;
    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Brief    : Directed self-checking bench, NUM_REQ=2, CLKS_PER_BIT=10.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int c_CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int c_SLOTS = 11;
`else
    localparam int c_SLOTS = 10;
`endif
    localparam int c_FRAME = c_CPB * c_SLOTS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  req_ready;
    logic        tx;
    logic        busy;
    logic        grant_id;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_scheduler #(
        .NUM_REQ (2),
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx       (tx),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot 0..c_SLOTS-1 of a frame carrying b
    function automatic logic exp_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Entered at the negedge of frame cycle first_j; leaves at cycle c_FRAME+1
    task automatic frame_check(input string tag, input logic [7:0] b, input int first_j);
        for (int j = first_j; j <= c_FRAME; j++) begin
            chk({tag, "_tx"}, {31'd0, tx}, {31'd0, exp_bit(b, (j - 1) / c_CPB)});
            if (j == c_FRAME) chk({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1: idle after reset
        @(negedge clk);
        rst = 1'b0;
        chk("rst_grant", {31'd0, grant_id}, 32'd0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_lines", {28'd0, tx, busy, req_ready}, {28'd0, 4'b1000});
        end

        // 2: single byte A5 from requester 0
        req_valid = 2'b01;
        req_data  = 16'h00A5;
        #1 chk("a5_ready", {30'd0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("a5_grant", {31'd0, grant_id}, 32'd0);
        chk("a5_ready_busy", {30'd0, req_ready}, 32'h0);
        frame_check("a5", 8'hA5, 1);

        // 3: both valid, rotation 0,1,0 with one-cycle gap
        do_reset();
        req_valid = 2'b11;
        req_data  = 16'h2211;
        #1 chk("rr_first_ready", {30'd0, req_ready}, 32'h1);
        @(negedge clk);
        chk("rr_grant0", {31'd0, grant_id}, 32'd0);
        frame_check("rr11a", 8'h11, 1);
        chk("rr_second_ready", {30'd0, req_ready}, 32'h2);
        @(negedge clk);
        chk("rr_grant1", {31'd0, grant_id}, 32'd1);
        frame_check("rr22", 8'h22, 1);
        chk("rr_third_ready", {30'd0, req_ready}, 32'h1);
        @(negedge clk);
        chk("rr_grant0b", {31'd0, grant_id}, 32'd0);
        frame_check("rr11b", 8'h11, 1);
        req_valid = 2'b00;
        #1 chk("rr_drop_ready", {30'd0, req_ready}, 32'h0);
        @(negedge clk);
        chk("rr_drop_busy", {31'd0, busy}, 32'd0);

        // 4: reset in the middle of a frame
        do_reset();
        req_valid = 2'b01;
        req_data  = 16'h0000;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (34) @(negedge clk);
        chk("mid_tx_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {30'd0, tx, busy}, 32'h2);
        end
        req_valid = 2'b01;
        req_data  = 16'h003C;
        #1 chk("post_rst_ready", {30'd0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        frame_check("post_rst", 8'h3C, 1);

        // 5: requester 1 pulses while busy and must be ignored
        req_valid = 2'b01;
        req_data  = 16'hFF5A;
        @(negedge clk);
        req_valid = 2'b10;
        #1 chk("pulse_ready", {30'd0, req_ready}, 32'h0);
        chk("pulse_tx_start", {31'd0, tx}, 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        frame_check("pulse5a", 8'h5A, 2);
        for (int i = 0; i < 15; i++) begin
            chk("pulse_no_send", {30'd0, tx, busy}, 32'h2);
            @(negedge clk);
        end
        req_valid = 2'b01;
        req_data  = 16'hFF81;
        #1 chk("later_ready", {30'd0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("later_grant", {31'd0, grant_id}, 32'd0);
        frame_check("later81", 8'h81, 1);

        // 6: data 07 (parity slot is 1 when enabled, else stop)
        req_valid = 2'b10;
        req_data  = 16'h0700;
        #1 chk("d07_ready", {30'd0, req_ready}, 32'h2);
        @(negedge clk);
        req_valid = 2'b00;
        chk("d07_grant", {31'd0, grant_id}, 32'd1);
        frame_check("d07", 8'h07, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
